// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory access at a time from the pipeline,
// drives the data memory for WAIT cycles, then returns a one-cycle response.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_*               request handshake from the pipeline (valid/ready)
//   resp_valid/data     one-cycle completion pulse, load data or stored data
//   stall               combinational req_valid && !req_ready
//   mem_*               data memory interface (read data is combinational)
//
// Optional feature: define LSU_STORE_FWD_EN to add a one-entry store
// forwarding buffer that lets a load to the last stored address skip ACCESS.
module load_store_unit #(
    parameter int unsigned W    = 3,
    parameter int unsigned WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic       req_write,
    input  logic [W:0] req_addr,
    input  logic [W:0] req_wdata,
    output logic       req_ready,
    output logic       resp_valid,
    output logic [W:0] resp_data,
    output logic       stall,
    output logic [W:0] mem_address,
    output logic [W:0] mem_write_data,
    output logic       mem_control_write,
    input  logic [W:0] mem_read_data
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               op_write;
    logic               accept;
    logic               start_access;

    assign accept = req_valid && req_ready;
    assign stall  = req_valid && !req_ready;

`ifdef LSU_STORE_FWD_EN
    logic       fwd_valid;
    logic [W:0] fwd_addr;
    logic [W:0] fwd_data;
    logic       fwd_hit;

    // A load matching the last recorded store is answered from the buffer.
    assign fwd_hit      = accept && !req_write && fwd_valid && (fwd_addr == req_addr);
    assign start_access = accept && !fwd_hit;
`else
    assign start_access = accept;
`endif

    // Control FSM with registered outputs; mem_address/mem_write_data double
    // as the latched request address and data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            wait_cnt          <= '0;
            op_write          <= 1'b0;
            req_ready         <= 1'b1;
            resp_valid        <= 1'b0;
            resp_data         <= '0;
            mem_address       <= '0;
            mem_write_data    <= '0;
            mem_control_write <= 1'b0;
`ifdef LSU_STORE_FWD_EN
            fwd_valid         <= 1'b0;
            fwd_addr          <= '0;
            fwd_data          <= '0;
`endif
        end else begin
            resp_valid <= 1'b0;
            unique case (state)
                IDLE, RESP: begin
                    if (start_access) begin
                        state             <= ACCESS;
                        wait_cnt          <= CNT_W'(WAIT);
                        op_write          <= req_write;
                        mem_address       <= req_addr;
                        mem_write_data    <= req_wdata;
                        mem_control_write <= req_write;
                        req_ready         <= 1'b0;
                    end
`ifdef LSU_STORE_FWD_EN
                    else if (fwd_hit) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_data  <= fwd_data;
                        req_ready  <= 1'b1;
                    end
`endif
                    else begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                ACCESS: begin
                    // Final ACCESS cycle: capture the result and finish.
                    if (wait_cnt <= CNT_W'(1)) begin
                        state             <= RESP;
                        wait_cnt          <= '0;
                        resp_valid        <= 1'b1;
                        resp_data         <= op_write ? mem_write_data : mem_read_data;
                        mem_control_write <= 1'b0;
                        req_ready         <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
`ifdef LSU_STORE_FWD_EN
            // Every accepted store refreshes the forwarding entry.
            if (accept && req_write) begin
                fwd_valid <= 1'b1;
                fwd_addr  <= req_addr;
                fwd_data  <= req_wdata;
            end
`endif
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: instance a uses WAIT=1, instance b
// uses WAIT=3; both share the request inputs and have private memories.
module tb_load_store_unit;

    localparam int unsigned W      = 3;
    localparam int unsigned DW     = W + 1;
    localparam int          WAIT_A = 1;
    localparam int          WAIT_B = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_write;
    logic [DW-1:0] req_addr;
    logic [DW-1:0] req_wdata;

    logic          a_ready, a_rv, a_stall, a_we;
    logic [DW-1:0] a_rdata, a_maddr, a_mwdata, a_mrdata;
    logic          b_ready, b_rv, b_stall, b_we;
    logic [DW-1:0] b_rdata, b_maddr, b_mwdata, b_mrdata;

    logic [DW-1:0] mem_a [16];
    logic [DW-1:0] mem_b [16];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.W(W), .WAIT(WAIT_A)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(a_ready), .resp_valid(a_rv), .resp_data(a_rdata), .stall(a_stall),
        .mem_address(a_maddr), .mem_write_data(a_mwdata),
        .mem_control_write(a_we), .mem_read_data(a_mrdata)
    );

    load_store_unit #(.W(W), .WAIT(WAIT_B)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(b_ready), .resp_valid(b_rv), .resp_data(b_rdata), .stall(b_stall),
        .mem_address(b_maddr), .mem_write_data(b_mwdata),
        .mem_control_write(b_we), .mem_read_data(b_mrdata)
    );

    // Data memories: combinational read, write on the rising edge.
    assign a_mrdata = mem_a[a_maddr];
    assign b_mrdata = mem_b[b_maddr];
    always @(posedge clk) if (a_we) mem_a[a_maddr] <= a_mwdata;
    always @(posedge clk) if (b_we) mem_b[b_maddr] <= b_mwdata;

    // Two reset cycles; returns at a falling edge with inputs idle.
    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++; if (a_ready !== 1'b1) begin $display("FAIL reset_ready got=%b exp=1", a_ready); n_errors++; end
        n_checks++; if (a_rv !== 1'b0) begin $display("FAIL reset_resp_valid got=%b exp=0", a_rv); n_errors++; end
        n_checks++; if (a_rdata !== 4'h0) begin $display("FAIL reset_resp_data got=%h exp=0", a_rdata); n_errors++; end
        n_checks++; if (a_we !== 1'b0) begin $display("FAIL reset_mem_we got=%b exp=0", a_we); n_errors++; end
        n_checks++; if (a_stall !== 1'b0) begin $display("FAIL reset_stall got=%b exp=0", a_stall); n_errors++; end
        n_checks++; if (a_maddr !== 4'h0) begin $display("FAIL reset_mem_addr got=%h exp=0", a_maddr); n_errors++; end
    endtask

    task automatic test_store_load();
        mem_a[5] <= 4'h0;
        do_reset();
        // Store 0xA to address 5.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd5; req_wdata = 4'hA;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        n_checks++; if (a_we !== 1'b1) begin $display("FAIL st_c1_we got=%b exp=1", a_we); n_errors++; end
        n_checks++; if (a_maddr !== 4'd5) begin $display("FAIL st_c1_addr got=%h exp=5", a_maddr); n_errors++; end
        n_checks++; if (a_mwdata !== 4'hA) begin $display("FAIL st_c1_wdata got=%h exp=a", a_mwdata); n_errors++; end
        n_checks++; if (a_ready !== 1'b0) begin $display("FAIL st_c1_ready got=%b exp=0", a_ready); n_errors++; end
        @(negedge clk);
        n_checks++; if (a_rv !== 1'b1) begin $display("FAIL st_c2_rv got=%b exp=1", a_rv); n_errors++; end
        n_checks++; if (a_rdata !== 4'hA) begin $display("FAIL st_c2_data got=%h exp=a", a_rdata); n_errors++; end
        @(negedge clk);
        n_checks++; if (a_rv !== 1'b0) begin $display("FAIL st_c3_rv got=%b exp=0", a_rv); n_errors++; end
        n_checks++; if (a_rdata !== 4'hA) begin $display("FAIL st_c3_hold got=%h exp=a", a_rdata); n_errors++; end
        // Load back address 5.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd5; req_wdata = 4'h0;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        n_checks++; if (a_we !== 1'b0) begin $display("FAIL ld_c1_we got=%b exp=0", a_we); n_errors++; end
`ifdef LSU_STORE_FWD_EN
        n_checks++; if (a_rv !== 1'b1) begin $display("FAIL ld_c1_fwd_rv got=%b exp=1", a_rv); n_errors++; end
        n_checks++; if (a_rdata !== 4'hA) begin $display("FAIL ld_c1_fwd_data got=%h exp=a", a_rdata); n_errors++; end
        @(negedge clk);
        n_checks++; if (a_rv !== 1'b0) begin $display("FAIL ld_c2_fwd_rv got=%b exp=0", a_rv); n_errors++; end
`else
        n_checks++; if (a_maddr !== 4'd5) begin $display("FAIL ld_c1_addr got=%h exp=5", a_maddr); n_errors++; end
        n_checks++; if (a_rv !== 1'b0) begin $display("FAIL ld_c1_rv got=%b exp=0", a_rv); n_errors++; end
        @(negedge clk);
        n_checks++; if (a_rv !== 1'b1) begin $display("FAIL ld_c2_rv got=%b exp=1", a_rv); n_errors++; end
        n_checks++; if (a_rdata !== 4'hA) begin $display("FAIL ld_c2_data got=%h exp=a", a_rdata); n_errors++; end
`endif
    endtask

    task automatic test_wait3();
        mem_b[2] <= 4'h3;
        mem_b[7] <= 4'h9;
        do_reset();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd2;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge clk);
            if (cyc == 1) req_addr = 4'd7;  // second request, held while stalled
            #1;
            n_checks++; if (b_ready !== 1'b0) begin $display("FAIL w3_ready cyc=%0d got=%b exp=0", cyc, b_ready); n_errors++; end
            n_checks++; if (b_stall !== 1'b1) begin $display("FAIL w3_stall cyc=%0d got=%b exp=1", cyc, b_stall); n_errors++; end
            n_checks++; if (b_rv !== 1'b0) begin $display("FAIL w3_rv cyc=%0d got=%b exp=0", cyc, b_rv); n_errors++; end
        end
        @(negedge clk);
        #1;
        n_checks++; if (b_rv !== 1'b1) begin $display("FAIL w3_c4_rv got=%b exp=1", b_rv); n_errors++; end
        n_checks++; if (b_rdata !== 4'h3) begin $display("FAIL w3_c4_data got=%h exp=3", b_rdata); n_errors++; end
        n_checks++; if (b_ready !== 1'b1) begin $display("FAIL w3_c4_ready got=%b exp=1", b_ready); n_errors++; end
        n_checks++; if (b_stall !== 1'b0) begin $display("FAIL w3_c4_stall got=%b exp=0", b_stall); n_errors++; end
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++; if (b_maddr !== 4'd7) begin $display("FAIL w3_c5_addr got=%h exp=7", b_maddr); n_errors++; end
        repeat (3) @(negedge clk);
        n_checks++; if (b_rv !== 1'b1) begin $display("FAIL w3_c8_rv got=%b exp=1", b_rv); n_errors++; end
        n_checks++; if (b_rdata !== 4'h9) begin $display("FAIL w3_c8_data got=%h exp=9", b_rdata); n_errors++; end
    endtask

    task automatic test_reset_abort();
        do_reset();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd3; req_wdata = 4'h6;
        @(negedge clk);
        n_checks++; if (a_we !== 1'b1) begin $display("FAIL ab_c1_we got=%b exp=1", a_we); n_errors++; end
        // Reset together with a new load: reset wins.
        reset = 1'b1; req_write = 1'b0; req_addr = 4'd4;
        @(negedge clk);
        reset = 1'b0; req_valid = 1'b0;
        n_checks++; if (a_we !== 1'b0) begin $display("FAIL ab_c2_we got=%b exp=0", a_we); n_errors++; end
        for (int cyc = 2; cyc <= 5; cyc++) begin
            n_checks++; if (a_rv !== 1'b0) begin $display("FAIL ab_rv cyc=%0d got=%b exp=0", cyc, a_rv); n_errors++; end
            n_checks++; if (a_ready !== 1'b1) begin $display("FAIL ab_ready cyc=%0d got=%b exp=1", cyc, a_ready); n_errors++; end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        mem_a[1] <= 4'hC;
        mem_a[2] <= 4'h5;
        do_reset();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd1;
        @(negedge clk);
        req_addr = 4'd2;
        #1;
        n_checks++; if (a_stall !== 1'b1) begin $display("FAIL b2b_c1_stall got=%b exp=1", a_stall); n_errors++; end
        @(negedge clk);
        n_checks++; if (a_rv !== 1'b1) begin $display("FAIL b2b_c2_rv got=%b exp=1", a_rv); n_errors++; end
        n_checks++; if (a_rdata !== 4'hC) begin $display("FAIL b2b_c2_data got=%h exp=c", a_rdata); n_errors++; end
        n_checks++; if (a_ready !== 1'b1) begin $display("FAIL b2b_c2_ready got=%b exp=1", a_ready); n_errors++; end
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++; if (a_rv !== 1'b0) begin $display("FAIL b2b_c3_rv got=%b exp=0", a_rv); n_errors++; end
        n_checks++; if (a_maddr !== 4'd2) begin $display("FAIL b2b_c3_addr got=%h exp=2", a_maddr); n_errors++; end
        @(negedge clk);
        n_checks++; if (a_rv !== 1'b1) begin $display("FAIL b2b_c4_rv got=%b exp=1", a_rv); n_errors++; end
        n_checks++; if (a_rdata !== 4'h5) begin $display("FAIL b2b_c4_data got=%h exp=5", a_rdata); n_errors++; end
    endtask

    // Random traffic on instance a against a transaction-level timing model.
    task automatic test_random();
        logic [DW-1:0] model_mem [16];
        logic [DW-1:0] exp_addr, exp_wdata, resp_hold, resp_next, v;
        logic          acc_wr, pending, exp_ready, exp_we, hit;
        logic          fv;
        logic [DW-1:0] fa, fd;
        int            free_at, resp_at, acc_lo, acc_hi;
        for (int i = 0; i < 16; i++) begin
            v = DW'($urandom);
            mem_a[i]     <= v;
            model_mem[i] = v;
        end
        do_reset();
        free_at = 0; resp_at = -1; acc_lo = 1; acc_hi = 0; acc_wr = 1'b0;
        exp_addr = '0; exp_wdata = '0; resp_hold = '0; resp_next = '0;
        pending = 1'b0; fv = 1'b0; fa = '0; fd = '0;
        for (int c = 0; c < 400; c++) begin
            if (c == resp_at) resp_hold = resp_next;
            exp_ready = (c >= free_at);
            exp_we    = acc_wr && (c >= acc_lo) && (c <= acc_hi);
            n_checks++; if (a_ready !== exp_ready) begin $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, a_ready, exp_ready); n_errors++; end
            n_checks++; if (a_rv !== (c == resp_at)) begin $display("FAIL rnd_rv cyc=%0d got=%b exp=%b", c, a_rv, (c == resp_at)); n_errors++; end
            n_checks++; if (a_rdata !== resp_hold) begin $display("FAIL rnd_data cyc=%0d got=%h exp=%h", c, a_rdata, resp_hold); n_errors++; end
            n_checks++; if (a_we !== exp_we) begin $display("FAIL rnd_we cyc=%0d got=%b exp=%b", c, a_we, exp_we); n_errors++; end
            n_checks++; if (a_maddr !== exp_addr) begin $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", c, a_maddr, exp_addr); n_errors++; end
            n_checks++; if (a_mwdata !== exp_wdata) begin $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", c, a_mwdata, exp_wdata); n_errors++; end
            if (!pending) begin
                req_valid = ($urandom_range(0, 2) != 0);
                req_write = 1'($urandom_range(0, 1));
                req_addr  = DW'($urandom_range(0, 7));
                req_wdata = DW'($urandom);
            end
            #1;
            n_checks++; if (a_stall !== (req_valid && !exp_ready)) begin $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", c, a_stall, (req_valid && !exp_ready)); n_errors++; end
            pending = req_valid && !exp_ready;
            if (req_valid && exp_ready) begin
                hit = 1'b0;
`ifdef LSU_STORE_FWD_EN
                hit = !req_write && fv && (fa == req_addr);
`endif
                if (hit) begin
                    free_at   = c + 1;
                    resp_at   = c + 1;
                    resp_next = fd;
                end else begin
                    free_at   = c + WAIT_A + 1;
                    resp_at   = c + WAIT_A + 1;
                    acc_lo    = c + 1;
                    acc_hi    = c + WAIT_A;
                    acc_wr    = req_write;
                    exp_addr  = req_addr;
                    exp_wdata = req_wdata;
                    resp_next = req_write ? req_wdata : model_mem[req_addr];
                    if (req_write) model_mem[req_addr] = req_wdata;
                end
                if (req_write) begin
                    fv = 1'b1; fa = req_addr; fd = req_wdata;
                end
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_wait3();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter W, default 3: data and address ports are [W:0].
REQ-002 Parameter WAIT, default 1: number of ACCESS cycles per memory access; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  pipeline presents an access request.
REQ-006 req_write  input  1  request type: 1 = store, 0 = load.
REQ-007 req_addr  input  [W:0]  request address.
REQ-008 req_wdata  input  [W:0]  store data.
REQ-009 req_ready  output  1  unit accepts a request this cycle.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_data  output  [W:0]  load result, or the stored data for a store.
REQ-012 stall  output  1  combinational; equals req_valid && !req_ready.
REQ-013 mem_address  output  [W:0]  data memory address.
REQ-014 mem_write_data  output  [W:0]  data memory write data.
REQ-015 mem_control_write  output  1  data memory write enable.
REQ-016 mem_read_data  input  [W:0]  data memory read data, combinational from mem_address.

Function
REQ-017 FSM states: IDLE, ACCESS, RESP.
REQ-018 req_ready shall be 1 in IDLE and RESP, and 0 in ACCESS.
REQ-019 Acceptance: a request presented in cycle t with req_valid && req_ready shall latch req_write, req_addr and req_wdata, then move to ACCESS at cycle t+1.
  - Transition IDLE->ACCESS, or RESP->ACCESS for back-to-back requests.
REQ-020 ACCESS duration: ACCESS shall last exactly WAIT cycles (t+1..t+WAIT), counted by a wait counter loaded on acceptance.
REQ-021 ACCESS outputs: throughout ACCESS, mem_address and mem_write_data shall equal the latched address and data.
  - mem_control_write shall equal the latched req_write.
REQ-022 Outside ACCESS, mem_control_write shall be 0.
  - mem_address and mem_write_data hold their last values.
REQ-023 Load capture: on a load, mem_read_data shall be captured into resp_data at the end of the final ACCESS cycle.
REQ-024 Store response: on a store, resp_data shall be loaded with the stored data.
REQ-025 RESP shall occur in cycle t+WAIT+1, with resp_valid = 1 for exactly that cycle.
  - Next state from RESP: ACCESS if a request is accepted, else IDLE.
REQ-026 resp_data shall hold its value until the next response.
REQ-027 Requests presented while req_ready = 0 shall be ignored and shall not be latched.
  - The requester holds the request while stall = 1.
REQ-028 Throughput: one access per WAIT+1 cycles.
REQ-029 Addresses: all values 0..2^(W+1)-1 are legal; there is no wrap or range check.

Reset
REQ-030 When reset = 1 at a rising edge, the unit shall clear to:
  - state IDLE and wait counter 0;
  - resp_valid 0 and resp_data 0;
  - mem_address 0, mem_write_data 0, mem_control_write 0;
  - forwarding entry invalid.
REQ-031 Reset during ACCESS or RESP shall abort the access: no resp_valid, and mem_control_write = 0 from the next cycle.
REQ-032 Reset takes priority over a simultaneous request; that request is not accepted.

Configuration
REQ-033 Macro LSU_STORE_FWD_EN enables a one-entry store-forwarding buffer.
REQ-034 With LSU_STORE_FWD_EN defined, every accepted store shall record (valid, addr, data) into the forwarding entry.
REQ-035 With LSU_STORE_FWD_EN defined, a forwarding hit is an accepted load whose address matches a valid entry.
  - The load goes directly to RESP in cycle t+1 with resp_data = the entry data.
  - No ACCESS state, and mem outputs unchanged.
REQ-036 Without LSU_STORE_FWD_EN, no forwarding state shall exist, and every load shall go through ACCESS.

Verification (W=3, WAIT=1 unless stated)
REQ-037 Reset released, inputs idle -> req_ready=1; resp_valid=0, resp_data=0, mem_control_write=0, stall=0.
REQ-038 Store addr 5 data 0xA in cycle 0 -> cycle 1: mem_control_write=1, mem_address=5, mem_write_data=0xA; cycle 2: resp_valid=1, resp_data=0xA.
REQ-039 Load addr 5 after REQ-038 store, with memory model:
  - without macro -> cycle 1 mem_address=5, mem_control_write=0; cycle 2 resp_valid=1, resp_data=0xA;
  - with macro -> cycle 1 resp_valid=1, resp_data=0xA, mem_control_write=0.
REQ-040 WAIT=3, load addr 2 (memory holds 0x3) in cycle 0, second request held from cycle 1:
  - cycles 1-3: req_ready=0, stall=1;
  - cycle 4: resp_valid=1, resp_data=0x3, second request accepted.
REQ-041 Store accepted in cycle 0, reset=1 in cycle 1 -> cycle 2: mem_control_write=0, req_ready=1; resp_valid never asserted.
REQ-042 Back-to-back loads of addresses 1 then 2, each held until accepted -> resp_valid in cycles 2 and 4; the second request is accepted in RESP cycle 2.
